// File: rtl/clk_source_if.sv
// Control and status bundle for the clock source: the requester drives the
// enable and divisor load, the clock source reports its generated clock and status.
interface clk_source_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic             div_load;
  logic             clk_out;
  logic             active;
  logic             load_ack;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output en, div, div_load,
    input  clk_out, active, load_ack, rise_cnt
  );

  modport slave (
    input  en, div, div_load,
    output clk_out, active, load_ack, rise_cnt
  );
endinterface

// File: rtl/clk_source.sv
// Programmable clock generator: clk_out has a half-period of div_eff clk
// cycles. A stop request never truncates a high phase, and a divisor change
// made while running waits for the next clk_out toggle so that the
// half-period in progress finishes at the old length.
module clk_source #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  clk_source_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] pend_val;
  logic             pend;
  logic             clk_q;
  logic             ack_q;
  logic             active_q;
  logic [CNT_W-1:0] rise_q;
  logic [DIV_W-1:0] div_eff;
  logic             terminal;

  // Zero divisor behaves as one; terminal marks the last cycle of a half-period.
  always_comb begin
    div_eff  = (div_reg == '0) ? DIV_W'(1) : div_reg;
    terminal = (cnt == (div_eff - DIV_W'(1)));
  end

  // Main state machine: phase counting, clk_out toggling, divisor loading, edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_reg  <= DIV_W'(1);
      pend_val <= '0;
      pend     <= 1'b0;
      clk_q    <= 1'b0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
      rise_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          clk_q <= 1'b0;
          // A fresh load wins over one left pending when the clock stopped.
          if (bus.div_load || pend) begin
            div_reg <= bus.div_load ? bus.div : pend_val;
            ack_q   <= 1'b1;
            pend    <= 1'b0;
          end
          if (bus.en) begin
            state    <= RUN;
            active_q <= 1'b1;
          end
        end

        RUN, STOP: begin
          if (!bus.en && !clk_q) begin
            // Stopping in the low phase: quit at once, no partial pulse.
            state    <= IDLE;
            active_q <= 1'b0;
            cnt      <= '0;
          end else begin
            if (terminal) begin
              cnt   <= '0;
              clk_q <= ~clk_q;
              if (!clk_q) begin
                rise_q <= rise_q + 1'b1;
              end
              if (pend) begin
                div_reg <= pend_val;
                ack_q   <= 1'b1;
                pend    <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end

            if (bus.en) begin
              state    <= RUN;
              active_q <= 1'b1;
            end else if (terminal) begin
              // Only reachable with clk_out high, so this is the falling toggle.
              state    <= IDLE;
              active_q <= 1'b0;
            end else begin
              state    <= STOP;
              active_q <= 1'b1;
            end
          end
          // Loads while running are deferred; a later one overwrites an earlier one.
          if (bus.div_load) begin
            pend     <= 1'b1;
            pend_val <= bus.div;
          end
        end

        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
          cnt      <= '0;
          clk_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out  = clk_q;
  assign bus.active   = active_q;
  assign bus.load_ack = ack_q;
  assign bus.rise_cnt = rise_q;

endmodule

// File: tb/tb_clk_source.sv
// Bench for clk_source: directed scenarios with hand-derived expectations,
// then randomized enable/load traffic checked every cycle against a
// behavioural model of the generated clock.
module tb_clk_source;
  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  clk_source_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  clk_source #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  bit cmp_en       = 0;

  typedef struct packed {
    bit running;
    bit level;
    bit ack;
    bit has_pend;
    int elapsed;
    int divisor;
    int pend;
    int rises;
  } model_t;

  model_t m;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.divisor = 1;
    return r;
  endfunction

  // One clk cycle of the generated clock in terms of half-periods and level.
  function automatic model_t model_step(model_t cur, logic en, int dv, logic ld);
    model_t nxt;
    int     half;
    bit     flip;
    nxt     = cur;
    nxt.ack = 1'b0;
    half    = (cur.divisor == 0) ? 1 : cur.divisor;
    if (!cur.running) begin
      if (ld || cur.has_pend) begin
        nxt.divisor  = ld ? dv : cur.pend;
        nxt.ack      = 1'b1;
        nxt.has_pend = 1'b0;
      end
      nxt.running = en;
      nxt.level   = 1'b0;
      nxt.elapsed = 0;
    end else if (!en && !cur.level) begin
      nxt.running = 1'b0;
      nxt.elapsed = 0;
      if (ld) begin
        nxt.has_pend = 1'b1;
        nxt.pend     = dv;
      end
    end else begin
      flip = (cur.elapsed + 1 >= half);
      if (flip) begin
        nxt.level   = !cur.level;
        nxt.elapsed = 0;
        if (!cur.level) nxt.rises = (cur.rises + 1) % (1 << CNT_W);
        if (cur.has_pend) begin
          nxt.divisor  = cur.pend;
          nxt.ack      = 1'b1;
          nxt.has_pend = 1'b0;
        end
      end else begin
        nxt.elapsed = cur.elapsed + 1;
      end
      if (ld) begin
        nxt.has_pend = 1'b1;
        nxt.pend     = dv;
      end
      if (!en && flip) nxt.running = 1'b0;
    end
    return nxt;
  endfunction

  // Advance the reference model alongside the DUT, including async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, bus.en, int'(bus.div), bus.div_load);
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_clk_out",  32'(bus.clk_out),  32'(m.level));
      check_output("model_active",   32'(bus.active),   32'(m.running));
      check_output("model_load_ack", 32'(bus.load_ack), 32'(m.ack));
      check_output("model_rise_cnt", 32'(bus.rise_cnt), 32'(m.rises));
    end
  end

  task automatic apply_stimulus(input logic e, input logic [DIV_W-1:0] d, input logic l);
    bus.en       = e;
    bus.div      = d;
    bus.div_load = l;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.en       = 1'b0;
    bus.div      = '0;
    bus.div_load = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic wait_level(input logic lvl, input int max, input string name, output int n);
    n = 0;
    while (bus.clk_out !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.clk_out !== lvl) check_output({name, "_timeout"}, 32'(bus.clk_out), 32'(lvl));
  endtask

  task automatic measure_phase(input logic lvl, output int n);
    n = 0;
    while (bus.clk_out === lvl && n < 600) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Load 3, run, and check latency, duty and edge count against hand values.
  task automatic basic_div3();
    int n;
    apply_stimulus(1'b0, 8'd3, 1'b1);
    check_output("ack_idle_load", 32'(bus.load_ack), 32'd1);
    check_output("idle_clk_low", 32'(bus.clk_out), 32'd0);
    apply_stimulus(1'b1, 8'd3, 1'b0);
    check_output("run_active", 32'(bus.active), 32'd1);
    check_output("ack_single", 32'(bus.load_ack), 32'd0);
    wait_level(1'b1, 20, "first_rise", n);
    check_output("first_rise_delay", 32'(n), 32'd3);
    measure_phase(1'b1, n);
    check_output("div3_high", 32'(n), 32'd3);
    measure_phase(1'b0, n);
    check_output("div3_low", 32'(n), 32'd3);
    repeat (12) @(negedge clk);
    check_output("div3_rise_cnt_4", 32'(bus.rise_cnt), 32'd4);
    check_output("div3_high_again", 32'(bus.clk_out), 32'd1);
  endtask

  initial begin
    int n;
    int r;
    int guard;
    logic prev;
    logic e;
    bus.en       = 1'b0;
    bus.div      = '0;
    bus.div_load = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);

    $display("[TB] basic divisor 3");
    do_reset();
    check_output("reset_clk_out", 32'(bus.clk_out), 32'd0);
    check_output("reset_active", 32'(bus.active), 32'd0);
    check_output("reset_rise_cnt", 32'(bus.rise_cnt), 32'd0);
    basic_div3();

    $display("[TB] divisor 0 acts as 1");
    do_reset();
    apply_stimulus(1'b0, 8'd0, 1'b1);
    check_output("div0_ack", 32'(bus.load_ack), 32'd1);
    apply_stimulus(1'b1, 8'd0, 1'b0);
    prev = bus.clk_out;
    repeat (6) begin
      @(negedge clk);
      check_output("div0_toggle", 32'(bus.clk_out), 32'(!prev));
      prev = bus.clk_out;
    end

    $display("[TB] stop in high and low phase at divisor 4");
    do_reset();
    apply_stimulus(1'b0, 8'd4, 1'b1);
    apply_stimulus(1'b1, 8'd4, 1'b0);
    wait_level(1'b1, 30, "div4_rise", n);
    n = 0;
    while (bus.clk_out === 1'b1 && n < 20) begin
      n++;
      if (n == 1) bus.en = 1'b0;
      if (n == 3) check_output("stop_active", 32'(bus.active), 32'd1);
      @(negedge clk);
    end
    check_output("stop_high_len", 32'(n), 32'd4);
    check_output("stop_to_idle", 32'(bus.active), 32'd0);
    bus.en = 1'b1;
    wait_level(1'b1, 30, "div4_rise2", n);
    wait_level(1'b0, 30, "div4_fall2", n);
    bus.en = 1'b0;
    @(negedge clk);
    check_output("low_stop_idle", 32'(bus.active), 32'd0);
    check_output("low_stop_clk", 32'(bus.clk_out), 32'd0);

    $display("[TB] divisor change 2 to 5 mid-phase");
    do_reset();
    apply_stimulus(1'b0, 8'd2, 1'b1);
    apply_stimulus(1'b1, 8'd2, 1'b0);
    wait_level(1'b1, 30, "div2_rise", n);
    bus.div      = 8'd5;
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    check_output("old_half_hold", 32'(bus.clk_out), 32'd1);
    check_output("no_early_ack", 32'(bus.load_ack), 32'd0);
    @(negedge clk);
    check_output("old_half_end", 32'(bus.clk_out), 32'd0);
    check_output("ack_at_toggle", 32'(bus.load_ack), 32'd1);
    measure_phase(1'b0, n);
    check_output("new_low_len", 32'(n), 32'd5);
    measure_phase(1'b1, n);
    check_output("new_high_len", 32'(n), 32'd5);

    $display("[TB] rise counter wrap");
    do_reset();
    apply_stimulus(1'b0, 8'd0, 1'b1);
    apply_stimulus(1'b1, 8'd0, 1'b0);
    r     = 0;
    guard = 0;
    prev  = bus.clk_out;
    while (r < 17 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (!prev && bus.clk_out) r++;
      prev = bus.clk_out;
    end
    check_output("wrap_rises_seen", 32'(r), 32'd17);
    check_output("wrap_rise_cnt", 32'(bus.rise_cnt), 32'd1);

    $display("[TB] async reset mid high phase");
    apply_stimulus(1'b1, 8'd3, 1'b1);
    wait_level(1'b1, 30, "rst_rise", n);
    wait_level(1'b0, 30, "rst_fall", n);
    wait_level(1'b1, 30, "rst_rise2", n);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_clk_out", 32'(bus.clk_out), 32'd0);
    check_output("async_rise_cnt", 32'(bus.rise_cnt), 32'd0);
    check_output("async_active", 32'(bus.active), 32'd0);
    check_output("async_load_ack", 32'(bus.load_ack), 32'd0);
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    basic_div3();

    $display("[TB] randomized traffic");
    e = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) e = !e;
      if ($urandom_range(0, 9) == 0)
        apply_stimulus(e, DIV_W'($urandom_range(0, 6)), 1'b1);
      else
        apply_stimulus(e, DIV_W'($urandom_range(0, 6)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
